// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge port between the MEM-stage access
// controller (master) and the data memory (slave).
interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer. Latches the EX/MEM load/store,
// holds a req/ack transaction on the memory port, stalls the pipeline until
// the access completes or times out, and returns the load word plus a
// one-cycle bus error flag. All state moves on the falling clock edge so it
// lines up with the pipeline registers it freezes.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     exmem_mem_r,
    input  logic                     exmem_mem_w,
    input  logic                     exmem_flush,
    input  logic [31:0]              exmem_addr,
    input  logic [31:0]              exmem_wdata,
    input  logic [3:0]               exmem_byte_en,
    mem_access_ctrl_if.master        mem,
    output logic                     mem_stall,
    output logic [31:0]              mem_data,
    output logic                     bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             start;
    logic             timeout_hit;

    assign start       = (exmem_mem_r | exmem_mem_w) & ~exmem_flush;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // Next-state and stall decode; the stall is combinational so the
    // pipeline freezes on the same edge the access is accepted.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
        state_nxt = state;
        mem_stall = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUSY;
                    mem_stall = 1'b1;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (mem.mem_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, timeout counter, memory port and result registers, updated on
    // the falling edge together with the pipeline registers.
    always_ff @(negedge clk) begin
        // NOTE: non-blocking assignments keep every register reading the pre-edge values, whatever the statement order.
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'h0;
            mem.mem_wdata <= 32'h0;
            mem.mem_be    <= 4'h0;
            mem_data      <= 32'h0;
            bus_err       <= 1'b0;
        end else begin
            state   <= state_nxt;
            // bus_err is only ever set on the BUSY->DONE timeout edge, so
            // clearing it by default makes it a single DONE-cycle pulse.
            bus_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // A request with both load and store set is a store.
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= exmem_mem_w;
                        mem.mem_addr  <= {exmem_addr[31:2], 2'b00};
                        mem.mem_wdata <= exmem_wdata;
                        mem.mem_be    <= exmem_mem_w ? exmem_byte_en : 4'hF;
                        cnt           <= '0;
                    end
                end
                BUSY: begin
                    // A late flush cannot cancel the bus transaction; it
                    // completes and the squash is honoured downstream.
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        if (!mem.mem_we) begin
                            mem_data <= mem.mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        mem.mem_req <= 1'b0;
                        mem_data    <= 32'h0;
                        bus_err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
